mult_ctrl_param: RTL and testbench

Parametrised control path for the chunked RV32M multiplier datapath. It sequences operand load, NCHUNK partial-product accumulation steps and a PIPE_DEPTH pipeline drain, then pulses done and returns to idle. Unlike the fixed 4-step controller, it adds:
- a start/abort/hold handshake,
- a chunk index output,
- optional early termination.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_step_counter.sv | 41 ++++
 rtl/mult_ctrl_param.sv | 172 +++++++++++++++++
 tb/tb_mult_ctrl_param.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the chunked multiplier control path.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MULT  = 2'b01,
    DRAIN = 2'b11,
    DONE  = 2'b10
  } mult_state_t;

  localparam int MULT_NCHUNK_DEF     = 4;
  localparam int MULT_PIPE_DEPTH_DEF = 2;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Loadable up/down step counter.
// Priority: clear > hold > load > count.
module mult_step_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         cnt_en_i,
  input  logic         up_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count selection.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_en_i) begin
      cnt_d = up_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mult_ctrl_param.sv
// Parametrised control path for the chunked RV32M multiplier datapath.
// Sequences IDLE -> MULT (NCHUNK steps) -> DRAIN (PIPE_DEPTH steps) -> DONE.
// Handshake: start_i is accepted only in IDLE with hold_i=0 and abort_i=0
// (op_ready_o shows IDLE); abort_i wins over everything and returns to IDLE
// without done_o; hold_i freezes state and counters and masks all enables.
// Optional feature macro: MULT_CTRL_EARLY_OUT_EN (leave MULT early when the
// remaining B chunks are all zero).
module mult_ctrl_param
  import mult_pkg::*;
#(
  parameter  int NCHUNK     = MULT_NCHUNK_DEF,
  parameter  int PIPE_DEPTH = MULT_PIPE_DEPTH_DEF,
  localparam int IDX_W      = $clog2(NCHUNK)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             hold_i,
  input  logic             b_rest_zero_i,
  output logic             op_ready_o,
  output logic             busy_o,
  output logic             reg_A_en_o,
  output logic             reg_B_en_o,
  output logic             AC_en_o,
  output logic             AC_clr_o,
  output logic             en_pipe_o,
  output logic             mux_B_sel_o,
  output logic             rol_en_o,
  output logic [IDX_W-1:0] chunk_idx_o,
  output logic             done_o
);

  localparam int                DCNT_W     = cnt_width(PIPE_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NCHUNK - 1);
  localparam logic [DCNT_W-1:0] DCNT_START = DCNT_W'(PIPE_DEPTH - 1);

  mult_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              idx_clr, idx_inc;
  logic              dcnt_clr, dcnt_load, dcnt_dec;
  logic              early_out;

`ifdef MULT_CTRL_EARLY_OUT_EN
  assign early_out = b_rest_zero_i && (idx_q != IDX_LAST);
`else
  logic unused_b_rest_zero;
  assign unused_b_rest_zero = b_rest_zero_i;
  assign early_out          = 1'b0;
`endif

  // Next-state and counter control; abort first, then hold, then sequencing.
  always_comb begin
    state_d   = state_q;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    dcnt_clr  = 1'b0;
    dcnt_load = 1'b0;
    dcnt_dec  = 1'b0;
    if (abort_i) begin
      state_d  = IDLE;
      idx_clr  = 1'b1;
      dcnt_clr = 1'b1;
    end else if (!hold_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = MULT;
            idx_clr = 1'b1;
          end
        end
        MULT: begin
          if (idx_q == IDX_LAST || early_out) begin
            state_d   = DRAIN;
            idx_clr   = 1'b1;
            dcnt_load = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt_q == '0) state_d = DONE;
          else              dcnt_dec = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  mult_step_counter #(.W(IDX_W)) u_idx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (idx_clr),
    .hold_i     (hold_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_en_i   (idx_inc),
    .up_i       (1'b1),
    .cnt_o      (idx_q)
  );

  mult_step_counter #(.W(DCNT_W)) u_dcnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (dcnt_clr),
    .hold_i     (hold_i),
    .load_i     (dcnt_load),
    .load_val_i (DCNT_START),
    .cnt_en_i   (dcnt_dec),
    .up_i       (1'b0),
    .cnt_o      (dcnt_q)
  );

  // Output decode from state and idx; hold_i masks every enable.
  always_comb begin
    op_ready_o  = 1'b0;
    busy_o      = 1'b0;
    reg_A_en_o  = 1'b0;
    reg_B_en_o  = 1'b0;
    AC_en_o     = 1'b0;
    AC_clr_o    = 1'b0;
    en_pipe_o   = 1'b0;
    mux_B_sel_o = 1'b0;
    rol_en_o    = 1'b0;
    chunk_idx_o = '0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        reg_A_en_o = 1'b1;
        reg_B_en_o = 1'b1;
        op_ready_o = 1'b1;
      end
      MULT: begin
        reg_B_en_o  = 1'b1;
        AC_en_o     = 1'b1;
        en_pipe_o   = 1'b1;
        mux_B_sel_o = 1'b1;
        rol_en_o    = 1'b1;
        busy_o      = 1'b1;
        chunk_idx_o = idx_q;
        AC_clr_o    = (idx_q == '0);
      end
      DRAIN: begin
        AC_en_o   = 1'b1;
        en_pipe_o = 1'b1;
        busy_o    = 1'b1;
      end
      DONE: begin
        done_o = 1'b1;
        busy_o = 1'b1;
      end
      default: ;
    endcase
    if (hold_i) begin
      reg_A_en_o = 1'b0;
      reg_B_en_o = 1'b0;
      AC_en_o    = 1'b0;
      AC_clr_o   = 1'b0;
      en_pipe_o  = 1'b0;
      rol_en_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_ctrl_param.sv
// Directed bench for mult_ctrl_param: default instance (4 chunks, 2 drain)
// and a wide instance (8 chunks, 3 drain) sharing the same stimulus.
module tb_mult_ctrl_param;

  logic clk_i = 1'b0;
  logic rst_i, start_i, abort_i, hold_i, b_rest_zero_i;

  logic       rdy4, busy4, ra4, rb4, acen4, acclr4, pipe4, mux4, rol4, done4;
  logic [1:0] idx4;
  logic       rdy8, busy8, ra8, rb8, acen8, acclr8, pipe8, mux8, rol8, done8;
  logic [2:0] idx8;

  int total = 0;
  int bad   = 0;

`ifdef MULT_CTRL_EARLY_OUT_EN
  localparam int EXP_EO_DONE = 5;
`else
  localparam int EXP_EO_DONE = 7;
`endif

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test end");
    $fatal(1, "watchdog");
  end

  mult_ctrl_param dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .hold_i(hold_i), .b_rest_zero_i(b_rest_zero_i),
    .op_ready_o(rdy4), .busy_o(busy4), .reg_A_en_o(ra4), .reg_B_en_o(rb4),
    .AC_en_o(acen4), .AC_clr_o(acclr4), .en_pipe_o(pipe4), .mux_B_sel_o(mux4),
    .rol_en_o(rol4), .chunk_idx_o(idx4), .done_o(done4)
  );

  mult_ctrl_param #(.NCHUNK(8), .PIPE_DEPTH(3)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .hold_i(hold_i), .b_rest_zero_i(b_rest_zero_i),
    .op_ready_o(rdy8), .busy_o(busy8), .reg_A_en_o(ra8), .reg_B_en_o(rb8),
    .AC_en_o(acen8), .AC_clr_o(acclr8), .en_pipe_o(pipe8), .mux_B_sel_o(mux8),
    .rol_en_o(rol8), .chunk_idx_o(idx8), .done_o(done8)
  );

  // Reset both instances; returns on a falling edge with inputs idle.
  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; hold_i = 1'b0; b_rest_zero_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b1;
    #1;
    total++;
    if ({rdy4, ra4, rb4, busy4, acen4, acclr4, pipe4, mux4, rol4, done4, idx4} !== 12'b1110_0000_0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b required %b",
               {rdy4, ra4, rb4, busy4, acen4, acclr4, pipe4, mux4, rol4, done4, idx4}, 12'b1110_0000_0000);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    #1;
    total++;
    if (idx4 !== 2'd2 || busy4 !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_idx: got idx=%0d busy=%b required idx=2 busy=1", idx4, busy4);
    end
    #1 rst_i = 1'b1;
    #1;
    total++;
    if (rdy4 !== 1'b1 || busy4 !== 1'b0 || idx4 !== 2'd0 || acen4 !== 1'b0 || rol4 !== 1'b0 || ra4 !== 1'b1) begin
      bad++;
      $display("FAIL reset_async: got rdy=%b busy=%b idx=%0d acen=%b rol=%b ra=%b required 1 0 0 0 0 1",
               rdy4, busy4, idx4, acen4, rol4, ra4);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_default_run();
    int first_done, n_done;
    logic [1:0] exp_idx;
    first_done = 0; n_done = 0;
    do_reset();
    start_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      #1;
      exp_idx = (k >= 1 && k <= 4) ? 2'(k - 1) : 2'd0;
      total++;
      if (idx4 !== exp_idx || acclr4 !== (k == 1) || rol4 !== (k <= 4) ||
          busy4 !== (k <= 7) || acen4 !== (k <= 6) || ra4 !== (k >= 8)) begin
        bad++;
        $display("FAIL default_cycle%0d: got idx=%0d clr=%b rol=%b busy=%b acen=%b ra=%b required idx=%0d clr=%b rol=%b busy=%b acen=%b ra=%b",
                 k, idx4, acclr4, rol4, busy4, acen4, ra4,
                 exp_idx, (k == 1), (k <= 4), (k <= 7), (k <= 6), (k >= 8));
      end
      if (done4 === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    total++;
    if (first_done != 7 || n_done != 1) begin
      bad++;
      $display("FAIL default_done: got first=%0d count=%0d required first=7 count=1", first_done, n_done);
    end
    total++;
    if (rdy4 !== 1'b1) begin
      bad++;
      $display("FAIL default_ready_after: got %b required 1", rdy4);
    end
  endtask

  task automatic test_hold_mult();
    int first_done, n_done;
    first_done = 0; n_done = 0;
    do_reset();
    start_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      hold_i = (k == 6 || k == 7);
      #1;
      if (k == 6 || k == 7) begin
        total++;
        if (idx8 !== 3'd5 || {ra8, rb8, acen8, acclr8, pipe8, rol8} !== 6'b0) begin
          bad++;
          $display("FAIL hold_frozen_cycle%0d: got idx=%0d en=%b required idx=5 en=000000",
                   k, idx8, {ra8, rb8, acen8, acclr8, pipe8, rol8});
        end
      end
      if (k == 8) begin
        total++;
        if (idx8 !== 3'd5 || acen8 !== 1'b1 || rol8 !== 1'b1) begin
          bad++;
          $display("FAIL hold_release: got idx=%0d acen=%b rol=%b required idx=5 acen=1 rol=1", idx8, acen8, rol8);
        end
      end
      if (done8 === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    hold_i = 1'b0;
    total++;
    if (first_done != 14 || n_done != 1) begin
      bad++;
      $display("FAIL hold_done: got first=%0d count=%0d required first=14 count=1", first_done, n_done);
    end
  endtask

  task automatic test_abort();
    int first_done, n_done;
    first_done = 0; n_done = 0;
    do_reset();
    start_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i);
      start_i = (k == 5 || k == 6);
      abort_i = (k == 5);
      #1;
      if (k == 5) begin
        total++;
        if (busy4 !== 1'b1 || acen4 !== 1'b1 || rol4 !== 1'b0) begin
          bad++;
          $display("FAIL abort_in_drain: got busy=%b acen=%b rol=%b required 1 1 0", busy4, acen4, rol4);
        end
      end
      if (k == 6) begin
        total++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
          bad++;
          $display("FAIL abort_idle: got rdy=%b busy=%b done=%b required 1 0 0", rdy4, busy4, done4);
        end
      end
      if (k == 7) begin
        total++;
        if (busy4 !== 1'b1 || acclr4 !== 1'b1 || idx4 !== 2'd0) begin
          bad++;
          $display("FAIL abort_restart: got busy=%b clr=%b idx=%0d required 1 1 0", busy4, acclr4, idx4);
        end
      end
      if (done4 === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    total++;
    if (first_done != 13 || n_done != 1) begin
      bad++;
      $display("FAIL abort_done: got first=%0d count=%0d required first=13 count=1", first_done, n_done);
    end
  endtask

  task automatic test_early_out();
    int first_done, n_done;
    first_done = 0; n_done = 0;
    do_reset();
    start_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      b_rest_zero_i = (k == 2);
      #1;
      if (done4 === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    b_rest_zero_i = 1'b0;
    total++;
    if (first_done != EXP_EO_DONE || n_done != 1) begin
      bad++;
      $display("FAIL early_out_done: got first=%0d count=%0d required first=%0d count=1",
               first_done, n_done, EXP_EO_DONE);
    end
  endtask

  task automatic test_done_hold();
    int first_done, last_done, n_done;
    first_done = 0; last_done = 0; n_done = 0;
    do_reset();
    start_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      hold_i = (k >= 7 && k <= 9);
      #1;
      if (k == 11) begin
        total++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0) begin
          bad++;
          $display("FAIL done_hold_idle: got rdy=%b busy=%b required 1 0", rdy4, busy4);
        end
      end
      if (done4 === 1'b1) begin
        n_done++;
        last_done = k;
        if (first_done == 0) first_done = k;
      end
    end
    hold_i = 1'b0;
    total++;
    if (first_done != 7 || last_done != 10 || n_done != 4) begin
      bad++;
      $display("FAIL done_hold_span: got first=%0d last=%0d count=%0d required 7 10 4",
               first_done, last_done, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int first_done, last_done, n_done;
    first_done = 0; last_done = 0; n_done = 0;
    do_reset();
    start_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i);
      #1;
      if (done4 === 1'b1) begin
        n_done++;
        last_done = k;
        if (first_done == 0) first_done = k;
      end
    end
    start_i = 1'b0;
    total++;
    if (first_done != 7 || last_done != 15 || n_done != 2) begin
      bad++;
      $display("FAIL back_to_back: got first=%0d last=%0d count=%0d required 7 15 2",
               first_done, last_done, n_done);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_default_run();
    test_hold_mult();
    test_abort();
    test_early_out();
    test_done_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
